// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer: funct3 encodings, entry layout, FSM states.
package store_buffer_pkg;

  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [2:0] F3_SB    = 3'b000;
  localparam logic [2:0] F3_SH    = 3'b001;
  localparam logic [2:0] F3_SW    = 3'b010;

  // Entries carry the widest supported address; narrower instances zero-extend.
  localparam int unsigned SB_ADDR_W_MAX = 64;

  typedef struct packed {
    logic [SB_ADDR_W_MAX-1:0] addr;
    logic [31:0]              wdata;
    logic [3:0]               be;
  } sb_entry_t;

  typedef enum logic {
    StIdle,
    StIssue
  } sb_state_e;

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane alignment for stores: byte enables, shifted data and legality check.
module store_lane_align
  import store_buffer_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_data,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_illegal
);

  logic [4:0] w_shamt;

  assign w_shamt = {i_offset, 3'b000};

  always_comb begin
    o_be      = 4'b0000;
    o_wdata   = 32'h0;
    o_illegal = 1'b0;
    unique case (i_funct3)
      F3_SB: begin
        o_be    = 4'b0001 << i_offset;
        o_wdata = {24'h0, i_data[7:0]} << w_shamt;
      end
      F3_SH: begin
        o_be      = 4'b0011 << i_offset;
        o_wdata   = {16'h0, i_data[15:0]} << w_shamt;
        o_illegal = i_offset[0];
      end
      F3_SW: begin
        o_be      = 4'b1111;
        o_wdata   = i_data;
        o_illegal = |i_offset;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// FIFO store buffer between MEM stage and data memory, with req/ack retirement
// and word-granular load hazard detection against pending stores.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [2:0]        st_funct3,
  output logic              st_err,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hazard,
  output logic              empty,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_d;
  sb_entry_t     r_entries [DEPTH];
  logic [DEPTH-1:0] r_valid;
  sb_state_e     r_state;
  sb_state_e     w_state_d;
  logic          r_err;

  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_illegal;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  sb_entry_t     w_new_entry;
  sb_entry_t     w_head;
  logic          w_unused;

  store_lane_align u_lane_align (
    .i_funct3  (st_funct3),
    .i_offset  (st_addr[1:0]),
    .i_data    (st_data),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_illegal (w_illegal)
  );

  // Ready comes from the registered count only, so a pop never frees a slot combinationally.
  assign st_ready = (r_count < FULL_CNT);
  assign empty    = (r_count == '0);
  assign w_accept = st_valid & st_ready;
  assign w_push   = w_accept & ~w_illegal;
  assign w_pop    = (r_state == StIssue) & mem_ack;
  assign st_err   = r_err;

  always_comb begin
    w_new_entry                   = '0;
    w_new_entry.addr[ADDR_W-1:0]  = st_addr;
    w_new_entry.wdata             = w_wdata;
    w_new_entry.be                = w_be;
  end

  always_comb begin
    w_count_d = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + CW'(1);
      2'b01:   w_count_d = r_count - CW'(1);
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
      r_err    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
    end else begin
      r_count <= w_count_d;
      r_err   <= w_accept & w_illegal;
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PW'(1);
      end
      if (w_push) begin
        r_entries[r_wr_ptr] <= w_new_entry;
        r_valid[r_wr_ptr]   <= 1'b1;
        r_wr_ptr            <= r_wr_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_count_d != '0) w_state_d = StIssue;
      StIssue: if (w_count_d == '0) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  assign w_head    = r_entries[r_rd_ptr];
  assign mem_req   = (r_state == StIssue);
  assign mem_addr  = mem_req ? {w_head.addr[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata = mem_req ? w_head.wdata : 32'h0;
  assign mem_be    = mem_req ? w_head.be : 4'b0000;

  // The head being popped this cycle is still valid here, so the load keeps stalling.
  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_entries[i].addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
        ld_hazard = 1'b1;
      end
    end
  end

  assign w_unused = ^{ld_addr[1:0], w_head.addr};

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a scoreboard queue of expected memory writes
// checked by a monitor, plus direct checks of ready, error, hazard and reset behaviour.
module tb_store_buffer;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_funct3;
  logic        st_err;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        empty;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  store_buffer #(
    .DEPTH  (4),
    .ADDR_W (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_funct3 (st_funct3),
    .st_err    (st_err),
    .ld_addr   (ld_addr),
    .ld_hazard (ld_hazard),
    .empty     (empty),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_exp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    exp_t e;
    e.addr  = a;
    e.wdata = d;
    e.be    = be;
    exp_q.push_back(e);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    st_addr   = a;
    st_data   = d;
    st_funct3 = f3;
    st_valid  = 1'b1;
    tick();
    st_valid  = 1'b0;
  endtask

  task automatic wait_empty(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (empty) break;
      tick();
    end
    chk("drain_empty", {31'h0, empty}, 32'h1);
  endtask

  // Monitor: every presented request must match the queue head; the head retires on ack.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && mem_req) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_req: got addr 0x%08h be %b, expected no request",
                   mem_addr, mem_be);
        end else begin
          n_cmp++;
          if (mem_addr !== exp_q[0].addr || mem_wdata !== exp_q[0].wdata ||
              mem_be !== exp_q[0].be) begin
            n_bad++;
            $display("FAIL mem_write: got addr 0x%08h data 0x%08h be %b, expected addr 0x%08h data 0x%08h be %b",
                     mem_addr, mem_wdata, mem_be, exp_q[0].addr, exp_q[0].wdata, exp_q[0].be);
          end
          if (mem_ack) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n     = 1'b0;
    st_valid  = 1'b0;
    st_addr   = 32'h0;
    st_data   = 32'h0;
    st_funct3 = 3'b000;
    ld_addr   = 32'h0;
    mem_ack   = 1'b0;
    #3;
    chk("rst_ready", {31'h0, st_ready}, 32'h1);
    chk("rst_err",   {31'h0, st_err},   32'h0);
    chk("rst_empty", {31'h0, empty},    32'h1);
    chk("rst_req",   {31'h0, mem_req},  32'h0);
    chk("rst_haz",   {31'h0, ld_hazard}, 32'h0);
    chk("rst_addr",  mem_addr,          32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1: sw, request right after the accepting edge, ack one cycle later
    add_exp(32'h100, 32'hDEADBEEF, 4'b1111);
    push(32'h100, 32'hDEADBEEF, SW);
    chk("t1_req_latency", {31'h0, mem_req}, 32'h1);
    chk("t1_not_empty",   {31'h0, empty},   32'h0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t1_empty_after", {31'h0, empty},   32'h1);
    chk("t1_req_after",   {31'h0, mem_req}, 32'h0);

    // 2: sb to the top byte lane
    add_exp(32'h200, 32'hAB000000, 4'b1000);
    push(32'h203, 32'h000000AB, SB);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t2_empty", {31'h0, empty}, 32'h1);

    // 3: misaligned and illegal stores are dropped with a one-cycle error
    push(32'h301, 32'h1234, SH);
    chk("t3_err_sh",   {31'h0, st_err}, 32'h1);
    chk("t3_empty_sh", {31'h0, empty},  32'h1);
    push(32'h402, 32'h55667788, SW);
    chk("t3_err_sw",   {31'h0, st_err}, 32'h1);
    push(32'h404, 32'h0, 3'b100);
    chk("t3_err_f3",   {31'h0, st_err}, 32'h1);
    tick();
    chk("t3_err_clear", {31'h0, st_err}, 32'h0);
    chk("t3_empty",     {31'h0, empty},  32'h1);

    // 4: fill, hold a fifth store, pop with it pending, then accept it
    add_exp(32'h10, 32'h01010101, 4'b1111);
    add_exp(32'h14, 32'h02020202, 4'b1111);
    add_exp(32'h18, 32'h03030303, 4'b1111);
    add_exp(32'h1C, 32'h00005500, 4'b0010);
    push(32'h10, 32'h01010101, SW);
    push(32'h14, 32'h02020202, SW);
    push(32'h18, 32'h03030303, SW);
    push(32'h1D, 32'h00000055, SB);
    chk("t4_full_ready", {31'h0, st_ready}, 32'h0);
    add_exp(32'h20, 32'hBEEF0000, 4'b1100);
    st_addr   = 32'h22;
    st_data   = 32'h0000BEEF;
    st_funct3 = SH;
    st_valid  = 1'b1;
    tick();
    chk("t4_held_ready", {31'h0, st_ready}, 32'h0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("t4_ready_after_pop", {31'h0, st_ready}, 32'h1);
    tick();
    st_valid = 1'b0;
    chk("t4_full_again", {31'h0, st_ready}, 32'h0);
    mem_ack = 1'b1;
    wait_empty(20);
    mem_ack = 1'b0;
    chk("t4_drained", exp_q.size(), 32'h0);

    // 5: load hazard on matching word, including the cycle the store retires
    add_exp(32'h500, 32'hCAFEF00D, 4'b1111);
    push(32'h500, 32'hCAFEF00D, SW);
    ld_addr = 32'h502;
    #1;
    chk("t5_haz_same_word", {31'h0, ld_hazard}, 32'h1);
    ld_addr = 32'h504;
    #1;
    chk("t5_haz_next_word", {31'h0, ld_hazard}, 32'h0);
    ld_addr = 32'h502;
    mem_ack = 1'b1;
    #1;
    chk("t5_haz_during_pop", {31'h0, ld_hazard}, 32'h1);
    tick();
    mem_ack = 1'b0;
    chk("t5_haz_after_ack", {31'h0, ld_hazard}, 32'h0);
    chk("t5_empty",         {31'h0, empty},     32'h1);

    // 6: reset with pending stores drops them all
    add_exp(32'h700, 32'h11111111, 4'b1111);
    add_exp(32'h704, 32'h00002222, 4'b0011);
    add_exp(32'h708, 32'h00330000, 4'b0100);
    push(32'h700, 32'h11111111, SW);
    push(32'h704, 32'h00002222, SH);
    push(32'h70A, 32'h00000033, SB);
    chk("t6_req_pending", {31'h0, mem_req}, 32'h1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_req_in_reset",   {31'h0, mem_req}, 32'h0);
    chk("t6_empty_in_reset", {31'h0, empty},   32'h1);
    chk("t6_be_in_reset",    {28'h0, mem_be},  32'h0);
    chk("t6_haz_in_reset",   {31'h0, ld_hazard}, 32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_replay", {31'h0, mem_req}, 32'h0);
    end
    add_exp(32'h600, 32'h12345678, 4'b1111);
    push(32'h600, 32'h12345678, SW);
    chk("t6_new_req", {31'h0, mem_req}, 32'h1);
    mem_ack = 1'b1;
    wait_empty(10);
    mem_ack = 1'b0;
    tick();
    chk("final_drained", exp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
